// File: rtl/load_ext_pkg.sv
// Shared types and funct3 decode helpers for the load extraction/extension stage.
package load_ext_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } funct3_e;

  // Encoded as log2 of the access size in bytes.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // funct3[1:0] is the size code for every legal load; bit 2 marks unsigned.
  function automatic size_e f3_size(input logic [2:0] f3);
    return size_e'(f3[1:0]);
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return ~f3[2];
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3, input int xlen);
    return (f3 == 3'b111) ||
           ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)));
  endfunction

endpackage

// File: rtl/load_ext_core.sv
// Combinational lane select, sign/zero extension and error flags for one load beat.
module load_ext_core
  import load_ext_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [OFFW-1:0] off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] res,
  output logic            misaligned,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN) + 1;

  size_e                   sz;
  logic                    sgn;
  logic [OFFW-1:0]         amask;
  int                      pad_i;
  logic [SHW-1:0]          pad;
  logic [XLEN-1:0]         lane_u;
  logic [XLEN-1:0]         ext_u;
  logic signed [XLEN-1:0]  lane_s;
  logic signed [XLEN-1:0]  ext_s;

  // The lane is shifted down to bit 0, pushed up against the MSB, then shifted
  // back so the fill (sign or zero) comes from the shift type alone.
  always_comb begin
    sz         = f3_size(funct3);
    sgn        = f3_signed(funct3);
    illegal    = f3_illegal(funct3, XLEN);
    amask      = OFFW'((1 << sz) - 1);
    misaligned = !illegal && (|(off & amask));
    pad_i      = XLEN - (8 << sz);
    pad        = (illegal || (pad_i < 0)) ? '0 : SHW'(pad_i);
    lane_u     = data >> {off, 3'b000};
    lane_s     = lane_u << pad;
    ext_s      = lane_s >>> pad;
    ext_u      = (lane_u << pad) >> pad;
    res        = sgn ? ext_s : ext_u;
    if (illegal || misaligned) begin
      res = '0;
    end
  end

endmodule

// File: rtl/load_ext_unit.sv
// Registered load extraction stage: extended results buffered in a main register
// plus a one-entry skid so writeback back-pressure never drops a load.
module load_ext_unit
  import load_ext_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [OFFW-1:0] in_off,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_misaligned,
  output logic            out_illegal
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("load_ext_unit: XLEN must be 32 or 64");
    end
  endgenerate

  state_e          state_q, state_d;
  logic            acc;
  logic            load_m_in, load_m_sk, load_s;

  logic [XLEN-1:0] res_p0;
  logic            mis_p0, ill_p0;

  logic [XLEN-1:0] m_data_p1, s_data_p1;
  logic [4:0]      m_rd_p1, s_rd_p1;
  logic            m_mis_p1, s_mis_p1;
  logic            m_ill_p1, s_ill_p1;

  load_ext_core #(.XLEN(XLEN)) u_core (
    .data       (in_data),
    .off        (in_off),
    .funct3     (in_funct3),
    .res        (res_p0),
    .misaligned (mis_p0),
    .illegal    (ill_p0)
  );

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_sk = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d   = ST_ONE;
            load_m_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && out_ready) begin
            load_m_in = 1'b1;
          end else if (acc) begin
            state_d = ST_FULL;
            load_s  = 1'b1;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d   = ST_ONE;
            load_m_sk = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---- stage p0 -> p1: main register drives the outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_p1 <= '0;
      m_rd_p1   <= '0;
      m_mis_p1  <= 1'b0;
      m_ill_p1  <= 1'b0;
    end else if (load_m_in) begin
      m_data_p1 <= res_p0;
      m_rd_p1   <= in_rd;
      m_mis_p1  <= mis_p0;
      m_ill_p1  <= ill_p0;
    end else if (load_m_sk) begin
      m_data_p1 <= s_data_p1;
      m_rd_p1   <= s_rd_p1;
      m_mis_p1  <= s_mis_p1;
      m_ill_p1  <= s_ill_p1;
    end
  end

  // ---- skid register: holds the beat accepted while M is stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data_p1 <= '0;
      s_rd_p1   <= '0;
      s_mis_p1  <= 1'b0;
      s_ill_p1  <= 1'b0;
    end else if (load_s) begin
      s_data_p1 <= res_p0;
      s_rd_p1   <= in_rd;
      s_mis_p1  <= mis_p0;
      s_ill_p1  <= ill_p0;
    end
  end

  assign out_data       = m_data_p1;
  assign out_rd         = m_rd_p1;
  assign out_misaligned = m_mis_p1;
  assign out_illegal    = m_ill_p1;

endmodule
